hilo_muldiv: RTL and testbench



---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_div_step.sv | 23 ++
 rtl/hilo_muldiv.sv | 186 ++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, opcode and state encodings for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;
    localparam int unsigned MULDIV_ITERS = 32;
    localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_ITERS);

    typedef enum logic [1:0] {
        MULDIV_OP_MULT  = 2'b00,
        MULDIV_OP_MULTU = 2'b01,
        MULDIV_OP_DIV   = 2'b10,
        MULDIV_OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } muldiv_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_i < divisor_i holds, so the top bit of trial is a clean borrow flag.
    assign shifted = {rem_i, dividend_bit_i};
    assign trial   = shifted - {1'b0, divisor_i};
    assign q_bit_o = ~trial[WIDTH];
    assign rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Optional MULDIV_FAST_MULT_EN: single-cycle combinational multiply in CALC.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    input  logic             MT_HI,
    input  logic             MT_LO,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_BY_ZERO,
    output logic [WIDTH-1:0] OUT_HI,
    output logic [WIDTH-1:0] OUT_LO
);

    localparam int unsigned CW = MULDIV_CNT_W;

    muldiv_state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic is_div_q, is_div_d;
    logic neg_lo_q, neg_lo_d;
    logic neg_hi_q, neg_hi_d;
    logic dbz_q, dbz_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic dbz_out_q, dbz_out_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign sign_a = op_is_signed(OP) & IN_A[WIDTH-1];
    assign sign_b = op_is_signed(OP) & IN_B[WIDTH-1];
    assign mag_a  = sign_a ? -IN_A : IN_A;
    assign mag_b  = sign_b ? -IN_B : IN_B;

    // Shift-add: multiplier sits in acc_lo and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_lo_q ? -prod : prod;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, opd_q} * {{WIDTH{1'b0}}, acc_lo_q};
`endif

    muldiv_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i         (acc_hi_q),
        .dividend_bit_i(acc_lo_q[WIDTH-1]),
        .divisor_i     (opd_q),
        .rem_o         (rem_next),
        .q_bit_o       (q_bit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opd_d     = opd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        dbz_d     = dbz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    busy_d   = 1'b1;
                    cnt_d    = CW'(MULDIV_ITERS - 1);
                    is_div_d = op_is_div(OP);
                    acc_hi_d = '0;
                    neg_lo_d = sign_a ^ sign_b;
                    neg_hi_d = sign_a;
                    if (op_is_div(OP)) begin
                        acc_lo_d = mag_a;
                        opd_d    = mag_b;
                        dbz_d    = (IN_B == '0);
                        state_d  = (IN_B == '0) ? FIX : CALC;
                    end else begin
                        acc_lo_d = mag_b;
                        opd_d    = mag_a;
                        dbz_d    = 1'b0;
                        state_d  = CALC;
                    end
                end else begin
                    if (MT_HI) hi_d = IN_A;
                    if (MT_LO) lo_d = IN_A;
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = FIX;
                if (is_div_q) begin
                    acc_hi_d = rem_next;
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], q_bit};
                end else begin
`ifdef MULDIV_FAST_MULT_EN
                    {acc_hi_d, acc_lo_d} = fast_prod;
                    state_d = FIX;
`else
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`endif
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (dbz_q) begin
                    dbz_out_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
                    hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opd_q     <= opd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign DIV_BY_ZERO = dbz_out_q;
    assign OUT_HI      = hi_q;
    assign OUT_LO      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv; latency expectations follow MULDIV_FAST_MULT_EN.
module tb_hilo_muldiv;

    // Edges counted from the START-sampling edge E0 (=1) up to the one after which DONE is seen.
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_EDGES = 3;
`else
    localparam int MUL_EDGES = 34;
`endif
    localparam int DIV_EDGES = 34;
    localparam int DBZ_EDGES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        mt_hi = 1'b0;
    logic        mt_lo = 1'b0;
    logic        busy, done, dbz;
    logic [31:0] out_hi, out_lo;

    int n_cmp = 0;
    int n_bad = 0;

    hilo_muldiv dut (
        .CLK        (clk),
        .RST        (rst),
        .START      (start),
        .OP         (op),
        .IN_A       (in_a),
        .IN_B       (in_b),
        .MT_HI      (mt_hi),
        .MT_LO      (mt_lo),
        .BUSY       (busy),
        .DONE       (done),
        .DIV_BY_ZERO(dbz),
        .OUT_HI     (out_hi),
        .OUT_LO     (out_lo)
    );

    always #5 clk = ~clk;

    // Launches one operation and waits (bounded) for DONE; mt drives MT_HI/MT_LO alongside START.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] mt, output int edges, output logic busy_ok,
                          output logic dbz_at_done);
        @(negedge clk);
        op = o; in_a = a; in_b = b; start = 1'b1;
        {mt_hi, mt_lo} = mt;
        @(posedge clk); #1;
        start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
        edges = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        dbz_at_done = dbz;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", dbz); end
        n_cmp++; if (out_hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", out_hi); end
        n_cmp++; if (out_lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", out_lo); end
    endtask

    task automatic test_multu_max;
        int e; logic bok, dz;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, e, bok, dz);
        n_cmp++; if (e !== MUL_EDGES) begin n_bad++; $display("FAIL multu_latency: got %0d want %0d", e, MUL_EDGES); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL multu_busy: got %b want 1", bok); end
        n_cmp++; if (out_hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", out_hi); end
        n_cmp++; if (out_lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", out_lo); end
        n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL multu_dbz: got %b want 0", dz); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult_signed;
        int e; logic bok, dz;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 2'b00, e, bok, dz);
        n_cmp++; if (out_hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", out_hi); end
        n_cmp++; if (out_lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_lo: got %h want ffffffeb", out_lo); end
    endtask

    task automatic test_div_signed;
        int e; logic bok, dz;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 2'b00, e, bok, dz);
        n_cmp++; if (e !== DIV_EDGES) begin n_bad++; $display("FAIL div_latency: got %0d want %0d", e, DIV_EDGES); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL div_busy: got %b want 1", bok); end
        n_cmp++; if (out_lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", out_lo); end
        n_cmp++; if (out_hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", out_hi); end
    endtask

    task automatic test_divu;
        int e; logic bok, dz;
        run_op(2'b11, 32'h8000_0000, 32'd3, 2'b00, e, bok, dz);
        n_cmp++; if (out_lo !== 32'h2AAA_AAAA) begin n_bad++; $display("FAIL divu_lo: got %h want 2aaaaaaa", out_lo); end
        n_cmp++; if (out_hi !== 32'h0000_0002) begin n_bad++; $display("FAIL divu_hi: got %h want 00000002", out_hi); end
    endtask

    task automatic test_div_overflow;
        int e; logic bok, dz;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, e, bok, dz);
        n_cmp++; if (out_lo !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo: got %h want 80000000", out_lo); end
        n_cmp++; if (out_hi !== 32'h0) begin n_bad++; $display("FAIL divovf_hi: got %h want 0", out_hi); end
        n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL divovf_dbz: got %b want 0", dz); end
    endtask

    task automatic test_mt_regs;
        @(negedge clk); mt_hi = 1'b1; mt_lo = 1'b1; in_a = 32'h77;
        @(posedge clk); #1 mt_hi = 1'b0; mt_lo = 1'b0;
        n_cmp++; if (out_hi !== 32'h77) begin n_bad++; $display("FAIL mt_both_hi: got %h want 77", out_hi); end
        n_cmp++; if (out_lo !== 32'h77) begin n_bad++; $display("FAIL mt_both_lo: got %h want 77", out_lo); end
        @(negedge clk); mt_hi = 1'b1; in_a = 32'h11;
        @(posedge clk); #1 mt_hi = 1'b0;
        @(negedge clk); mt_lo = 1'b1; in_a = 32'h22;
        @(posedge clk); #1 mt_lo = 1'b0;
        n_cmp++; if (out_hi !== 32'h11) begin n_bad++; $display("FAIL mthi: got %h want 11", out_hi); end
        n_cmp++; if (out_lo !== 32'h22) begin n_bad++; $display("FAIL mtlo: got %h want 22", out_lo); end
    endtask

    task automatic test_div_by_zero;
        int e; logic bok, dz;
        run_op(2'b11, 32'd5, 32'd0, 2'b00, e, bok, dz);
        n_cmp++; if (e !== DBZ_EDGES) begin n_bad++; $display("FAIL dbz_latency: got %0d want %0d", e, DBZ_EDGES); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL dbz_busy: got %b want 1", bok); end
        n_cmp++; if (dz !== 1'b1) begin n_bad++; $display("FAIL dbz_flag: got %b want 1", dz); end
        n_cmp++; if (out_hi !== 32'h11) begin n_bad++; $display("FAIL dbz_hi: got %h want 11", out_hi); end
        n_cmp++; if (out_lo !== 32'h22) begin n_bad++; $display("FAIL dbz_lo: got %h want 22", out_lo); end
        @(posedge clk); #1;
        n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL dbz_pulse: got %b want 0", dbz); end
    endtask

    task automatic test_start_wins;
        int e; logic bok, dz;
        // MT_HI alongside START: HI must not take IN_A (=5); the product replaces it later.
        run_op(2'b01, 32'd5, 32'd6, 2'b10, e, bok, dz);
        n_cmp++; if (out_hi !== 32'h0) begin n_bad++; $display("FAIL startwins_hi: got %h want 0", out_hi); end
        n_cmp++; if (out_lo !== 32'd30) begin n_bad++; $display("FAIL startwins_lo: got %h want 1e", out_lo); end
    endtask

    task automatic test_busy_ignore_and_reset;
        int e; logic bok, dz; int done_seen;
        @(negedge clk); mt_hi = 1'b1; in_a = 32'h55;
        @(posedge clk); #1 mt_hi = 1'b0;
        @(negedge clk); op = 2'b01; in_a = 32'h10; in_b = 32'h10; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); mt_hi = 1'b1; in_a = 32'hDEAD; op = 2'b11; in_b = 32'h0; start = 1'b1;
        @(posedge clk); #1 mt_hi = 1'b0; start = 1'b0;
        n_cmp++; if (out_hi !== 32'h55) begin n_bad++; $display("FAIL busy_mthi: got %h want 55", out_hi); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_held: got %b want 1", busy); end
        n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL busy_start_dbz: got %b want 0", dbz); end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_cmp++; if (out_hi !== 32'h0) begin n_bad++; $display("FAIL midrst_hi: got %h want 0", out_hi); end
        n_cmp++; if (out_lo !== 32'h0) begin n_bad++; $display("FAIL midrst_lo: got %h want 0", out_lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", done_seen); end
        run_op(2'b01, 32'd3, 32'd4, 2'b00, e, bok, dz);
        n_cmp++; if (e !== MUL_EDGES) begin n_bad++; $display("FAIL postrst_latency: got %0d want %0d", e, MUL_EDGES); end
        n_cmp++; if (out_lo !== 32'd12) begin n_bad++; $display("FAIL postrst_lo: got %h want 0c", out_lo); end
        n_cmp++; if (out_hi !== 32'h0) begin n_bad++; $display("FAIL postrst_hi: got %h want 0", out_hi); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div_signed();
        test_divu();
        test_div_overflow();
        test_mt_regs();
        test_div_by_zero();
        test_start_wins();
        test_busy_ignore_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
